// File: rtl/aes_engine_ctrl.sv
// Job sequencer for the AES HWPE engine.
// Requests the source and sink streamers, clears and enables the engine,
// counts finished 128-bit blocks and raises a one-cycle done event once the
// sink streamer has drained. Every output comes straight from a flop.
module aes_engine_ctrl #(
    parameter int CNT_W    = 16,
    parameter int FLUSH_TO = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] nblocks_i,
    output logic             src_req_o,
    input  logic             src_ack_i,
    output logic             sink_req_o,
    input  logic             sink_ack_i,
    input  logic             sink_done_i,
    output logic             eng_clear_o,
    output logic             eng_enable_o,
    input  logic             eng_blk_done_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    // Flush timeout counter only has to reach FLUSH_TO-1.
    localparam int              TO_W    = (FLUSH_TO < 2) ? 1 : $clog2(FLUSH_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((FLUSH_TO > 0) ? FLUSH_TO - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             src_req_q, src_req_d;
    logic             sink_req_q, sink_req_d;
    logic             err_q, err_d;
    logic             clear_q, enable_q, busy_q, done_q;

    // Next-state and next-register values; abort pre-empts everything but IDLE.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned -- that is what keeps this block from inferring latches.
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        to_cnt_d   = to_cnt_q;
        src_req_d  = src_req_q;
        sink_req_d = sink_req_q;
        err_d      = err_q;

        if (state_q != S_IDLE && abort_i) begin
            state_d    = S_IDLE;
            src_req_d  = 1'b0;
            sink_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_d = nblocks_i;
                        cnt_d = '0;
                        err_d = 1'b0;
                        if (nblocks_i == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_REQ;
                            src_req_d  = 1'b1;
                            sink_req_d = 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // A request that is already low has been acknowledged.
                    if (src_ack_i)  src_req_d  = 1'b0;
                    if (sink_ack_i) sink_req_d = 1'b0;
                    if (!src_req_d && !sink_req_d) state_d = S_CLEAR;
                end
                S_CLEAR: state_d = S_RUN;
                S_RUN: begin
                    if (eng_blk_done_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == len_q) begin
                            state_d  = S_FLUSH;
                            to_cnt_d = '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (sink_done_i) begin
                        state_d = S_DONE;
                    end else if (FLUSH_TO != 0 && to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next state so
    // they are flops with no input-to-output combinational path.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            to_cnt_q   <= '0;
            src_req_q  <= 1'b0;
            sink_req_q <= 1'b0;
            err_q      <= 1'b0;
            clear_q    <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            to_cnt_q   <= to_cnt_d;
            src_req_q  <= src_req_d;
            sink_req_q <= sink_req_d;
            err_q      <= err_d;
            clear_q    <= (state_d == S_CLEAR);
            enable_q   <= (state_d == S_RUN);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign src_req_o    = src_req_q;
    assign sink_req_o   = sink_req_q;
    assign eng_clear_o  = clear_q;
    assign eng_enable_o = enable_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign blk_cnt_o    = cnt_q;

endmodule

// File: tb/tb_aes_engine_ctrl.sv
// Bench for aes_engine_ctrl: a reactive driver plays the streamers and the
// engine, pushes the expected outcome of each job into a scoreboard, and an
// independent monitor pops it whenever done_o fires.
module tb_aes_engine_ctrl;

    localparam int CNT_W    = 16;
    localparam int FLUSH_TO = 8;

    logic             clk = 1'b0;
    logic             rst_i, start_i, abort_i;
    logic [CNT_W-1:0] nblocks_i;
    logic             src_req_o, src_ack_i, sink_req_o, sink_ack_i, sink_done_i;
    logic             eng_clear_o, eng_enable_o, eng_blk_done_i;
    logic             busy_o, done_o, err_o;
    logic [CNT_W-1:0] blk_cnt_o;

    aes_engine_ctrl #(.CNT_W(CNT_W), .FLUSH_TO(FLUSH_TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .nblocks_i(nblocks_i), .src_req_o(src_req_o), .src_ack_i(src_ack_i),
        .sink_req_o(sink_req_o), .sink_ack_i(sink_ack_i), .sink_done_i(sink_done_i),
        .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o),
        .eng_blk_done_i(eng_blk_done_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .blk_cnt_o(blk_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;     // final block count
        bit err;     // flush timeout expected
        bit stream;  // streamers and engine clear expected
        int lat;     // cycles from start to done_o
        int start;   // cyc when start_i was driven
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        start_i = 1'b0; abort_i = 1'b0; src_ack_i = 1'b0; sink_ack_i = 1'b0;
        sink_done_i = 1'b0; eng_blk_done_i = 1'b0;
    endtask

    // One job. ds/dk: ack delays, g: idle cycles between block pulses,
    // f: flush cycles before sink_done (-1 never), abort_at: abort together
    // with that block pulse, rst_at: reset once blk_cnt_o reaches it.
    task automatic run_job(input int n, input int ds, input int dk, input int g,
                           input int f, input int abort_at, input int rst_at,
                           input bit stray);
        exp_t e;
        int src_t = 0, snk_t = 0, gap_t = 0, sent = 0, fl_t = 0, budget = 0, m;
        bit fin = 0, stray_start_done = 0;
        m = (ds > dk) ? ds : dk;
        if (abort_at == 0 && rst_at == 0) begin
            e.cnt    = n;
            e.err    = (n != 0 && f < 0);
            e.stream = (n != 0);
            if (n == 0)     e.lat = 1;
            else if (f < 0) e.lat = 3 + m + n * (g + 1) + FLUSH_TO;
            else            e.lat = 4 + m + n * (g + 1) + f;
            e.start  = cyc;
            sb.push_back(e);
        end
        nblocks_i = CNT_W'(n);
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
        nblocks_i = CNT_W'($urandom());
        check("req raised one cycle after start", src_req_o, n != 0);
        check("err cleared by start", err_o, 0);
        check("busy after start", busy_o, 1);

        while (!fin) begin
            clear_inputs();
            if (done_o) begin
                if (f < 0 && n > 0) check("flush cycles before timeout", fl_t, FLUSH_TO);
                fin = 1;
            end else if (budget >= 400) begin
                check("job finished within budget", fin, 1);
                sb.delete();
                rst_i = 1'b1;
                repeat (2) @(negedge clk);
                rst_i = 1'b0;
                fin = 1;
            end else if (rst_at > 0 && eng_enable_o && int'(blk_cnt_o) == rst_at) begin
                rst_i = 1'b1;
                repeat (3) @(negedge clk);
                check("reset clears controls",
                      {src_req_o, sink_req_o, eng_clear_o, eng_enable_o, busy_o, done_o, err_o}, 0);
                check("reset clears blk_cnt", blk_cnt_o, 0);
                rst_i = 1'b0;
                fin = 1;
            end else begin
                if (src_req_o) begin
                    if (src_t == ds) src_ack_i = 1'b1;
                    src_t++;
                end
                if (sink_req_o) begin
                    if (snk_t == dk) sink_ack_i = 1'b1;
                    snk_t++;
                end
                if (eng_enable_o) begin
                    if (gap_t == g) begin
                        eng_blk_done_i = 1'b1;
                        gap_t = 0;
                        sent++;
                        if (sent == abort_at) abort_i = 1'b1;
                    end else begin
                        gap_t++;
                    end
                    if (stray && sent == 1 && !stray_start_done) begin
                        start_i   = 1'b1;
                        stray_start_done = 1;
                    end
                end else if (n > 0 && sent == n) begin
                    if (f >= 0 && fl_t == f) sink_done_i = 1'b1;
                    if (stray && fl_t == 0) eng_blk_done_i = 1'b1;
                    fl_t++;
                end
                if (abort_i) begin
                    @(negedge clk);
                    clear_inputs();
                    check("abort returns to idle", busy_o, 0);
                    check("abort holds blk_cnt", blk_cnt_o, abort_at - 1);
                    check("abort drops requests and enable",
                          {src_req_o, sink_req_o, eng_enable_o, eng_clear_o, done_o}, 0);
                    fin = 1;
                end else begin
                    @(negedge clk);
                end
                budget++;
            end
        end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    task automatic stray_idle_blk();
        logic [CNT_W-1:0] held;
        held = blk_cnt_o;
        eng_blk_done_i = 1'b1;
        @(negedge clk);
        eng_blk_done_i = 1'b0;
        @(negedge clk);
        check("idle blk_done ignored (count)", blk_cnt_o, held);
        check("idle blk_done ignored (busy)", busy_o, 0);
    endtask

    // Monitor: per-job protocol statistics and scoreboard pop on done_o.
    bit busy_prev, clear_prev, done_prev, clr_wide, req_seen, en_late, cnt_bad;
    int n_clear, last_cnt;
    initial begin : monitor
        exp_t e;
        busy_prev = 0; clear_prev = 0; done_prev = 0;
        clr_wide = 0; req_seen = 0; en_late = 0; cnt_bad = 0;
        n_clear = 0; last_cnt = 0;
        forever begin
            @(negedge clk);
            if (busy_o && !busy_prev) begin
                n_clear = 0; clr_wide = 0; req_seen = 0; en_late = 0; cnt_bad = 0;
                last_cnt = 0;
            end
            if (eng_clear_o && !clear_prev) n_clear++;
            if (eng_clear_o && clear_prev) clr_wide = 1;
            if (src_req_o || sink_req_o) req_seen = 1;
            if (sb.size() > 0 && eng_enable_o && int'(blk_cnt_o) >= sb[0].cnt) en_late = 1;
            if (int'(blk_cnt_o) != last_cnt) begin
                if (busy_o && int'(blk_cnt_o) != last_cnt + 1) cnt_bad = 1;
                last_cnt = int'(blk_cnt_o);
            end
            if (done_prev) check("busy falls with done", busy_o, 0);
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("done only for a live job", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("final blk_cnt", blk_cnt_o, e.cnt);
                    check("err at done", err_o, e.err);
                    check("start-to-done latency", cyc - e.start, e.lat);
                    check("engine clear pulses", n_clear, e.stream ? 1 : 0);
                    check("clear wider than one cycle", clr_wide, 0);
                    check("streamer requests seen", req_seen, e.stream);
                    check("enable held after last block", en_late, 0);
                    check("blk_cnt stepped by one", cnt_bad, 0);
                end
            end
            busy_prev  = busy_o;
            clear_prev = eng_clear_o;
            done_prev  = done_o;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int n, ds, dk, g, f, ab;
        rst_i = 1'b1;
        nblocks_i = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("reset controls",
              {src_req_o, sink_req_o, eng_clear_o, eng_enable_o, busy_o, done_o, err_o}, 0);
        check("reset blk_cnt", blk_cnt_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        run_job(1, 0, 0, 0, 0, 0, 0, 0);   // minimum job
        run_job(0, 0, 0, 0, 0, 0, 0, 0);   // zero length
        run_job(4, 2, 5, 2, 3, 0, 0, 0);   // normal job
        run_job(3, 1, 0, 1, 4, 0, 0, 1);   // start in RUN, blk_done in FLUSH
        stray_idle_blk();
        run_job(3, 0, 0, 2, 0, 2, 0, 0);   // abort with 2nd block
        run_job(1, 0, 0, 0, 0, 0, 0, 0);
        run_job(2, 0, 1, 0, -1, 0, 0, 0);  // flush timeout
        run_job(1, 1, 0, 0, 1, 0, 0, 0);   // err cleared again
        run_job(4, 0, 0, 2, 0, 0, 2, 0);   // reset mid-RUN
        run_job(2, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            n  = $urandom_range(0, 6);
            ds = $urandom_range(0, 4);
            dk = $urandom_range(0, 4);
            g  = $urandom_range(0, 3);
            f  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, 5);
            ab = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n) : 0;
            run_job(n, ds, dk, g, f, ab, 0, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
